// File: rtl/regfile_pkg.sv
// Shared widths, architectural register names and word/index types for the
// decode-stage register file and its scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 2;
  localparam int REG_A0   = 10;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: set on issue, cleared on writeback,
// wiped by flush. Also produces the per-read-port hazard flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [(1<<ADDR_W)-1:0]   busy_vec,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Issue is applied after writeback so a new producer outranks the retiring one.
  always_comb begin
    busy_nxt = busy_q;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
      if (iss_en) busy_nxt[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    // A writeback landing this cycle resolves the hazard, mirroring the bypass.
    assign rd_busy[i] = busy_q[a] & ~(wr_en && (wr_addr == a));
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NUM_RD combinational read ports, one write port,
// write-first bypass, a pending-write scoreboard and a debug tap register.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int DBG_REG  = REG_A0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [(1<<ADDR_W)-1:0]   busy_vec,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_IDX  = ADDR_W'(DBG_REG);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_ok;

  // Writes to a hardwired zero register are dropped before storage and bypass.
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ZERO_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    always_comb begin
      d = regs[a];
      if ((ZERO_REG != 0) && (a == ZERO_IDX)) d = '0;
      else if (wr_ok && (wr_addr == a))       d = wr_data;
    end
    assign rd_data[i*DATA_W +: DATA_W] = d;
  end

  assign dbg_data = regs[DBG_IDX];

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_ok),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .busy_vec (busy_vec),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, zero register, bypass, scoreboard
// lifecycle, set/clear priority, flush, debug tap and four-port reads.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [31:0]      busy_vec;
  logic [DW-1:0]    dbg_data;

  int n_vec = 0;
  int n_err = 0;

  regfile_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1),
    .DBG_REG  (REG_A0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_vec (busy_vec),
    .dbg_data (dbg_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    flush    = 1'b0;
  endtask

  task automatic set_rd(input int port, input int addr);
    rd_addr[port*AW +: AW] = AW'(addr);
  endtask

  task automatic drive_wr(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
  endtask

  task automatic drive_iss(input int addr);
    iss_en   = 1'b1;
    iss_addr = AW'(addr);
  endtask

  // finish the current cycle and move to the next negedge with idle inputs
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
  endtask

  function automatic logic [DW-1:0] port_data(input int port);
    return rd_data[port*DW +: DW];
  endfunction

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    set_rd(0, 5);
    #1;
    check("rst_busy_vec", 64'(busy_vec), 64'h0);
    check("rst_dbg", 64'(dbg_data), 64'h0);
    check("rst_rd_x5", 64'(port_data(0)), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // preload x10, then write+issue x5 so reset has state to wipe
    drive_wr(10, 32'h77);
    next_cycle();
    drive_wr(5, 32'hDEADBEEF);
    drive_iss(5);
    #1;
    check("pre_bypass_x5", 64'(port_data(0)), 64'hDEADBEEF);
    next_cycle();
    check("pre_rd_x5", 64'(port_data(0)), 64'hDEADBEEF);
    check("pre_busy_vec", 64'(busy_vec), 64'h20);
    check("pre_dbg", 64'(dbg_data), 64'h77);
    check("pre_rd_busy_x5", 64'(rd_busy[0]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rd_x5", 64'(port_data(0)), 64'h0);
    check("midrst_busy_vec", 64'(busy_vec), 64'h0);
    check("midrst_dbg", 64'(dbg_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // zero register: write and issue to x0 are both ignored
    set_rd(0, 0);
    set_rd(1, 0);
    drive_wr(0, 32'h1234);
    drive_iss(0);
    #1;
    check("x0_same_cycle", 64'(port_data(0)), 64'h0);
    next_cycle();
    check("x0_after", 64'(port_data(1)), 64'h0);
    check("x0_busy_vec", 64'(busy_vec), 64'h0);

    // write-first bypass on two ports
    set_rd(0, 7);
    set_rd(1, 7);
    drive_wr(7, 32'hCAFEF00D);
    #1;
    check("byp_p0", 64'(port_data(0)), 64'hCAFEF00D);
    check("byp_p1", 64'(port_data(1)), 64'hCAFEF00D);
    next_cycle();
    check("byp_reg_p0", 64'(port_data(0)), 64'hCAFEF00D);
    check("byp_reg_p1", 64'(port_data(1)), 64'hCAFEF00D);

    // scoreboard lifecycle on x3
    set_rd(0, 3);
    drive_iss(3);
    #1;
    check("iss_cycle_rd_busy", 64'(rd_busy[0]), 64'h0);
    next_cycle();
    check("iss_busy_vec", 64'(busy_vec), 64'h8);
    check("iss_rd_busy", 64'(rd_busy[0]), 64'h1);
    drive_wr(3, 32'd42);
    #1;
    check("wb_cycle_rd_busy", 64'(rd_busy[0]), 64'h0);
    check("wb_cycle_rd_data", 64'(port_data(0)), 64'd42);
    next_cycle();
    check("wb_busy_vec", 64'(busy_vec), 64'h0);
    check("wb_rd_data", 64'(port_data(0)), 64'd42);

    // simultaneous set and clear on x4: set wins
    drive_iss(4);
    drive_wr(4, 32'h44);
    next_cycle();
    check("setclr_busy_vec", 64'(busy_vec), 64'h10);
    // flush beats a same-cycle issue; the data write still lands
    set_rd(0, 8);
    flush = 1'b1;
    drive_iss(6);
    drive_wr(8, 32'h88);
    next_cycle();
    check("flush_busy_vec", 64'(busy_vec), 64'h0);
    check("flush_wr_x8", 64'(port_data(0)), 64'h88);

    // debug tap follows x10 one cycle after the write
    drive_wr(REG_A0, 32'h55AA);
    #1;
    check("dbg_write_cycle", 64'(dbg_data), 64'h0);
    next_cycle();
    check("dbg_after", 64'(dbg_data), 64'h55AA);

    // four distinct registers on four ports
    set_rd(0, 3);
    set_rd(1, 7);
    set_rd(2, 8);
    set_rd(3, 10);
    #1;
    check("rd4_p0", 64'(port_data(0)), 64'd42);
    check("rd4_p1", 64'(port_data(1)), 64'hCAFEF00D);
    check("rd4_p2", 64'(port_data(2)), 64'h88);
    check("rd4_p3", 64'(port_data(3)), 64'h55AA);
    check("rd4_busy", 64'(rd_busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the decode-stage integer register file.
- Provides NUM_RD combinational read ports, one synchronous write port and write-to-read bypass, so same-cycle writeback is visible to decode.
- Adds a per-register pending-write scoreboard, so the pipeline can detect RAW hazards on in-flight results.
- Adds a parametrised debug tap, which replaces the fixed a0 output.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = index 0 hardwired to zero and never marked busy; 0 = index 0 is an ordinary register.
- DBG_REG, 10, index driven on dbg_data.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data per port.
- rd_busy  out  NUM_RD  1 = the register read on port i has an unresolved pending write.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  writeback index.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  an instruction with a destination register issues this cycle.
- iss_addr  in  ADDR_W  destination index of the issuing instruction.
- flush  in  1  synchronous clear of all busy bits (branch mispredict / trap).
- busy_vec  out  NREGS  raw scoreboard state.
- dbg_data  out  DATA_W  current registered value of DBG_REG (no bypass).

Behaviour:
- Reset (rst_n low, asynchronous):
  - all NREGS registers <= 0; all busy bits <= 0.
  - Outputs follow combinationally: dbg_data = 0, busy_vec = 0, rd_busy = 0, rd_data = 0 unless bypass is active.
- Write: at posedge clk, if wr_en && !(ZERO_REG && wr_addr == 0), then reg[wr_addr] <= wr_data.
  - Writes to index 0 with ZERO_REG = 1 are discarded.
- Read, per port i, combinational with zero latency, in priority order:
  - (a) ZERO_REG && rd_addr_i == 0 -> 0.
  - (b) wr_en && wr_addr == rd_addr_i (and the write is not discarded) -> wr_data (write-first bypass).
  - (c) otherwise -> reg[rd_addr_i].
- Scoreboard, per register r, updated at posedge clk, in priority order:
  - flush -> busy[r] <= 0 for all r. flush overrides iss_en and wr_en in that cycle; the data write still occurs.
  - iss_en && iss_addr == r -> busy[r] <= 1. Set wins over a simultaneous clear from wr_en to the same index, because the new producer supersedes the retiring one.
  - wr_en && wr_addr == r -> busy[r] <= 0.
  - Otherwise hold.
  - With ZERO_REG = 1, busy[0] is constant 0.
- rd_busy_i = busy[rd_addr_i] & ~(wr_en && wr_addr == rd_addr_i).
  - A same-cycle writeback resolves the hazard, matching the bypass.
  - iss_en in the same cycle does not affect rd_busy, because the issuing instruction's sources are older than its destination.
- A writeback to a non-busy register is legal: data is written, busy stays 0, no error.
- Multiple issues to the same register before writeback keep busy = 1. The first writeback clears it; the scoreboard is single-bit and does not count producers. The pipeline guarantees in-order writeback per register.
- Reset asserted mid-operation aborts everything immediately. There is no partial write; the first edge after rst_n deasserts behaves as from cold.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W / ADDR_W defaults.
  - Named constants REG_ZERO = 0, REG_SP = 2, REG_A0 = 10.
  - typedef reg_idx_t (logic [ADDR_W-1:0]) and typedef word_t (logic [DATA_W-1:0]).
- One natural sub-module, regfile_scoreboard:
  - inputs: busy bits, set/clear/flush logic.
  - outputs: busy_vec and the masked per-port rd_busy.
- Storage and bypass mux remain in regfile_sb; read ports are built with a generate loop over NUM_RD.

Test Plan:
- Reset then read:
  - Stimulus: write 0xDEADBEEF to x5; assert rst_n = 0 mid-cycle.
  - Required: rd_data for x5 = 0 immediately; busy_vec = 0; dbg_data = 0.
- Zero register:
  - Stimulus: wr_en, wr_addr = 0, wr_data = 0x1234; iss_en to x0.
  - Required: reads of x0 return 0; busy_vec[0] = 0.
- Bypass:
  - Stimulus: same cycle, wr_en x7 = 0xCAFEF00D with rd_addr port0 = 7 and port1 = 7.
  - Required: both ports = 0xCAFEF00D that cycle; next cycle the registered value is also 0xCAFEF00D.
- Scoreboard lifecycle:
  - Stimulus: iss x3.
  - Required: next cycle busy_vec[3] = 1 and rd_busy = 1 when reading x3.
  - Stimulus: wr x3 = 42.
  - Required: rd_busy = 0 in the wr cycle; busy_vec[3] = 0 after.
- Simultaneous set/clear and flush:
  - Stimulus: iss x4 and wr x4 in the same cycle.
  - Required: busy[4] = 1 after.
  - Stimulus: then flush together with iss x6.
  - Required: busy_vec = 0.
- Debug tap, DBG_REG = 10, NUM_RD = 4:
  - Stimulus: write x10 = 0x55AA.
  - Required: dbg_data = 0x55AA one cycle later, not in the write cycle.
  - Stimulus: read four distinct registers.
  - Required: each port returns its own value.
